// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives imem via req/ack, buffers one instruction for IF/ID.
// Latency: wr_allow one cycle after ack; a redirect takes at least two cycles to the first new wr_allow.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr_out,
  output logic [31:0]      pc_out,
  output logic             wr_allow,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic        buf_valid;
  logic        started;
  logic        capture;

  assign imem_addr = pc;

  // The buffer may only be overwritten when empty or consumed this cycle,
  // so a full buffer under stall suppresses the request.
  always_comb begin
    imem_req  = started && (state == FETCH) && !(buf_valid && stall);
    wr_allow  = buf_valid && !stall && !redirect;
    capture   = imem_req && imem_ack && !redirect;
    state_nxt = state;
    if (redirect) begin
      state_nxt = FETCH;
    end else begin
      case (state)
        FETCH:   if (capture && stall) state_nxt = HOLD;
        HOLD:    if (!stall)           state_nxt = FETCH;
        default: state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      started     <= 1'b0;
      pc          <= RESET_PC & ~32'h3;
      buf_valid   <= 1'b0;
      instr_out   <= 32'h0;
      pc_out      <= 32'h0;
      fetch_count <= '0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
      if (redirect) begin
        pc        <= redirect_pc & ~32'h3;
        buf_valid <= 1'b0;
        instr_out <= 32'h0;
      end else if (capture) begin
        instr_out <= imem_rdata;
        pc_out    <= pc;
        buf_valid <= 1'b1;
        pc        <= pc + PC_STEP;
      end else if (wr_allow) begin
        buf_valid <= 1'b0;
      end
      if (wr_allow) fetch_count <= fetch_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit: table of per-cycle inputs/expected outputs plus reset and wrap sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect, imem_ack;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, wr_allow;
  logic [31:0] imem_addr, instr_out, pc_out;
  logic [15:0] fetch_count;

  logic        rst2_n;
  logic        req2, wr2;
  logic [31:0] addr2, instr2, pco2;
  logic [1:0]  cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_out(instr_out),
    .pc_out(pc_out), .wr_allow(wr_allow), .fetch_count(fetch_count)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(2)) dut_wrap (
    .clk(clk), .rst_n(rst2_n), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(1'b1), .imem_rdata(addr2), .instr_out(instr2),
    .pc_out(pco2), .wr_allow(wr2), .fetch_count(cnt2)
  );

  typedef struct {
    logic        s, r, a;
    logic [31:0] rpc, rd;
    logic        q;
    logic [31:0] ad;
    logic        w;
    logic [31:0] ins, pco;
    logic [15:0] c;
  } vec_t;

  function automatic vec_t mk(logic s, logic r, logic a, logic [31:0] rpc, logic [31:0] rd,
                              logic q, logic [31:0] ad, logic w, logic [31:0] ins,
                              logic [31:0] pco, logic [15:0] c);
    vec_t v;
    v.s = s; v.r = r; v.a = a; v.rpc = rpc; v.rd = rd;
    v.q = q; v.ad = ad; v.w = w; v.ins = ins; v.pco = pco; v.c = c;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  vec_t        vt [24];
  logic [31:0] w_addr [7];
  logic [1:0]  w_cnt  [7];

  initial begin
    //          s  r  a  rpc      rdata          | req addr     wr instr          pc_out   cnt
    vt[0]  = mk(0, 0, 1, 32'h0,   32'h0,          0, 32'h0,   0, 32'h0,          32'h0,   0);
    vt[1]  = mk(0, 0, 1, 32'h0,   32'h0,          1, 32'h0,   0, 32'h0,          32'h0,   0);
    vt[2]  = mk(0, 0, 1, 32'h0,   32'h4,          1, 32'h4,   1, 32'h0,          32'h0,   0);
    vt[3]  = mk(0, 0, 0, 32'h0,   32'h0,          1, 32'h8,   1, 32'h4,          32'h4,   1);
    vt[4]  = mk(0, 0, 0, 32'h0,   32'h0,          1, 32'h8,   0, 32'h4,          32'h4,   2);
    vt[5]  = mk(0, 0, 0, 32'h0,   32'h0,          1, 32'h8,   0, 32'h4,          32'h4,   2);
    vt[6]  = mk(0, 0, 1, 32'h0,   32'h8,          1, 32'h8,   0, 32'h4,          32'h4,   2);
    vt[7]  = mk(0, 0, 1, 32'h0,   32'hC,          1, 32'hC,   1, 32'h8,          32'h8,   2);
    vt[8]  = mk(0, 0, 1, 32'h0,   32'hDEADBEEF,   1, 32'h10,  1, 32'hC,          32'hC,   3);
    vt[9]  = mk(1, 0, 1, 32'h0,   32'h14,         0, 32'h14,  0, 32'hDEADBEEF,   32'h10,  4);
    vt[10] = mk(1, 0, 1, 32'h0,   32'h14,         0, 32'h14,  0, 32'hDEADBEEF,   32'h10,  4);
    vt[11] = mk(1, 0, 1, 32'h0,   32'h14,         0, 32'h14,  0, 32'hDEADBEEF,   32'h10,  4);
    vt[12] = mk(1, 0, 1, 32'h0,   32'h14,         0, 32'h14,  0, 32'hDEADBEEF,   32'h10,  4);
    vt[13] = mk(0, 0, 1, 32'h0,   32'h14,         1, 32'h14,  1, 32'hDEADBEEF,   32'h10,  4);
    vt[14] = mk(0, 0, 0, 32'h0,   32'h0,          1, 32'h18,  1, 32'h14,         32'h14,  5);
    vt[15] = mk(1, 0, 1, 32'h0,   32'h18,         1, 32'h18,  0, 32'h14,         32'h14,  6);
    vt[16] = mk(1, 0, 1, 32'h0,   32'h1C,         0, 32'h1C,  0, 32'h18,         32'h18,  6);
    vt[17] = mk(1, 1, 1, 32'h103, 32'h1C,         0, 32'h1C,  0, 32'h18,         32'h18,  6);
    vt[18] = mk(0, 0, 0, 32'h0,   32'h0,          1, 32'h100, 0, 32'h0,          32'h18,  6);
    vt[19] = mk(0, 0, 1, 32'h0,   32'hAAAA0100,   1, 32'h100, 0, 32'h0,          32'h18,  6);
    vt[20] = mk(0, 1, 1, 32'h200, 32'h104,        1, 32'h104, 0, 32'hAAAA0100,   32'h100, 6);
    vt[21] = mk(0, 0, 1, 32'h0,   32'h200,        1, 32'h200, 0, 32'h0,          32'h100, 6);
    vt[22] = mk(0, 0, 0, 32'h0,   32'h0,          1, 32'h204, 1, 32'h200,        32'h200, 6);
    vt[23] = mk(0, 0, 0, 32'h0,   32'h0,          1, 32'h204, 0, 32'h200,        32'h200, 7);

    w_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC};
    w_cnt  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst_n = 1'b0; rst2_n = 1'b0;
    stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
    redirect_pc = 32'h0; imem_rdata = 32'h0;

    @(negedge clk); @(negedge clk); #1;
    chk("rst_req",   {31'h0, imem_req},    32'h0);
    chk("rst_addr",  imem_addr,            32'h0);
    chk("rst_wr",    {31'h0, wr_allow},    32'h0);
    chk("rst_instr", instr_out,            32'h0);
    chk("rst_pcout", pc_out,               32'h0);
    chk("rst_cnt",   {16'h0, fetch_count}, 32'h0);

    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i > 0) @(negedge clk);
      stall = vt[i].s; redirect = vt[i].r; imem_ack = vt[i].a;
      redirect_pc = vt[i].rpc; imem_rdata = vt[i].rd;
      #1;
      chk($sformatf("v%0d_req", i),   {31'h0, imem_req},    {31'h0, vt[i].q});
      chk($sformatf("v%0d_addr", i),  imem_addr,            vt[i].ad);
      chk($sformatf("v%0d_wr", i),    {31'h0, wr_allow},    {31'h0, vt[i].w});
      chk($sformatf("v%0d_instr", i), instr_out,            vt[i].ins);
      chk($sformatf("v%0d_pcout", i), pc_out,               vt[i].pco);
      chk($sformatf("v%0d_cnt", i),   {16'h0, fetch_count}, {16'h0, vt[i].c});
    end

    // Asynchronous reset between edges while a request is outstanding.
    @(posedge clk); #2;
    chk("pre_arst_req", {31'h0, imem_req}, 32'h1);
    chk("pre_arst_cnt", {16'h0, fetch_count}, 32'h7);
    rst_n = 1'b0;
    #1;
    chk("arst_req",   {31'h0, imem_req},    32'h0);
    chk("arst_cnt",   {16'h0, fetch_count}, 32'h0);
    chk("arst_addr",  imem_addr,            32'h0);
    chk("arst_instr", instr_out,            32'h0);
    chk("arst_pcout", pc_out,               32'h0);
    chk("arst_wr",    {31'h0, wr_allow},    32'h0);

    // PC wrap through 2^32 and 2-bit counter wrap on the second instance.
    @(negedge clk);
    rst2_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("wrap%0d_addr", k), addr2, w_addr[k]);
      chk($sformatf("wrap%0d_cnt", k),  {30'h0, cnt2}, {30'h0, w_cnt[k]});
      chk($sformatf("wrap%0d_req", k),  {31'h0, req2}, (k == 0) ? 32'h0 : 32'h1);
      chk($sformatf("wrap%0d_wr", k),   {31'h0, wr2},  (k < 2)  ? 32'h0 : 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and drives a single-port instruction memory through a req/ack handshake.
- Buffers one fetched instruction and presents it with a write-enable (wr_allow) that the IF/ID register samples on the falling clock edge.
- Handles stalls from hazard logic and PC redirects from branch/jump resolution.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, PC increment per sequential fetch (byte-addressed, 32-bit instructions).
- CNT_W, 16, width of the fetched-instruction performance counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- stall  in  1  downstream cannot accept an instruction this cycle.
- redirect  in  1  branch/jump taken; load PC from redirect_pc.
- redirect_pc  in  32  new fetch address; low 2 bits are ignored (forced to 0).
- imem_req  out  1  instruction memory request.
- imem_addr  out  32  fetch address; always equals pc.
- imem_ack  in  1  memory accepted request; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_out  out  32  buffered instruction, wired to the IF/ID `in` port.
- pc_out  out  32  address of instr_out.
- wr_allow  out  1  instr_out is valid and not stalled; IF/ID captures it on negedge.
- fetch_count  out  CNT_W  number of instructions delivered (wr_allow cycles); wraps.

Behaviour:
Reset (rst_n=0, asynchronous, takes effect mid-operation without waiting for a clock edge):
- pc=RESET_PC, buf_valid=0, instr_out=0, pc_out=0, fetch_count=0.
- state=FETCH, imem_req=0.
- imem_req rises on the first rising edge after rst_n deasserts.

State machine:
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack: instr_out<=imem_rdata, pc_out<=pc, buf_valid<=1, pc<=pc+PC_STEP.
  - If stall=1 in the ack cycle, go to HOLD; otherwise stay in FETCH, giving back-to-back fetch at one instruction per cycle when ack is continuous.
  - Without ack: imem_addr stays stable and imem_req stays high.
- HOLD: imem_req=0; buffer is full and waiting for stall to drop.
  - stall=0 returns to FETCH.

Output logic:
- wr_allow = buf_valid & ~stall & ~redirect (combinational).
- buf_valid clears on any rising edge where wr_allow=1 and no new ack occurs in that cycle.
- Ack in the same cycle as consumption replaces the buffer, so buf_valid stays 1.
- In FETCH, a new ack may only overwrite the buffer if the buffer is empty or being consumed in that cycle. If buf_valid=1 and stall=1, imem_req is forced low.
- fetch_count increments by 1 on each rising edge where wr_allow=1; it wraps from all-ones to 0.

Redirect (highest priority, overrides stall and ack):
- pc<=redirect_pc & ~32'h3, buf_valid<=0, instr_out<=0 (NOP), state<=FETCH.
- Any ack in the redirect cycle is discarded; the memory tolerates abandoned requests.
- imem_addr shows the new target on the following cycle.

Arithmetic:
- pc wraps modulo 2^32; 32'hFFFF_FFFC+4 gives 0, with no flag.
- pc[1:0] is always 0.

Simultaneous events:
- redirect & stall: redirect wins.
- ack & stall with an empty buffer: capture, then HOLD.
- rst_n low with anything else: reset wins.

Latency:
- Request to wr_allow is 1 cycle after ack with zero-wait memory.
- Redirect to the first new wr_allow is at least 2 cycles.

Test Plan:
- Reset release, ack always 1, rdata=addr: imem_addr sequence 0,4,8,C; wr_allow high every cycle from cycle 2; pc_out tracks; fetch_count=4 after 4 deliveries.
- Ack delayed 3 cycles at addr 8: imem_addr holds 8 and imem_req stays 1 for 3 cycles; wr_allow low for 3 cycles; no PC skip.
- stall=1 for 4 cycles with buffered instr 0xDEADBEEF at pc 0x10: instr_out/pc_out held; wr_allow=0; imem_req=0 in HOLD; after release, 0xDEADBEEF is delivered exactly once, then 0x14 is fetched.
- redirect with redirect_pc=0x103 while stall=1 and buffer full: next cycle imem_addr=0x100, buf_valid=0, instr_out=0; the old instruction is never delivered.
- RESET_PC=0xFFFF_FFF8, sequential fetch: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert rst_n=0 between clock edges mid-fetch: outputs reset immediately; fetch_count=0 and imem_req=0 before the next edge.
